wb_host_seq: RTL
================

WB_HOST_SEQ -- requirements
Module: wb_host_seq

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: Wishbone cycles allowed without ack/err before abort (range 1..65535).
REQ-002 SHALL have port wb_clk_i, input, 1: the single clock; all logic is rising-edge.
REQ-003 SHALL have port wb_rst_i, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port cmd_valid_i, input, 1: command offered.
REQ-005 SHALL have port cmd_ready_o, output, 1: command accepted when high together with cmd_valid_i.
REQ-006 SHALL have port cmd_we_i, input, 1: 1 = write, 0 = read.
REQ-007 SHALL have port cmd_adr_i, input, 32: byte address.
REQ-008 SHALL have port cmd_dat_i, input, 32: write data.
REQ-009 SHALL have port cmd_sel_i, input, 4: byte lanes.
REQ-010 SHALL have ports wbm_cyc_o, wbm_stb_o and wbm_we_o, outputs, 1 each: Wishbone classic master controls.
REQ-011 SHALL have ports wbm_adr_o (32), wbm_dat_o (32) and wbm_sel_o (4), outputs: Wishbone address, write data and byte selects.
REQ-012 SHALL have ports wbm_dat_i (32), wbm_ack_i (1) and wbm_err_i (1), inputs: slave read data, ack and error.
REQ-013 SHALL have ports rsp_valid_o (1, output), rsp_ready_i (1, input), rsp_dat_o (32, output) and rsp_err_o (1, output): response channel.
REQ-014 SHALL have port txn_cnt_o, output, 16: count of completed transactions.

Function
REQ-015 SHALL implement FSM IDLE -> BUS -> RESP -> IDLE.
REQ-016 SHALL drive cmd_ready_o = 1 only in IDLE.
REQ-017 On the cmd handshake edge, SHALL register we/adr/dat/sel and enter BUS; cyc, stb and we SHALL be high from the next cycle.
REQ-018 In BUS, SHALL hold cyc, stb, adr, dat, sel and we stable until the edge at which ack_i or err_i is sampled high.
REQ-019 At that edge, SHALL drop cyc/stb, capture wbm_dat_i into rsp_dat_o (reads only; writes give 0), set rsp_err_o = err_i, and enter RESP.
REQ-020 If ack_i and err_i are both high, err SHALL win: rsp_err_o = 1 and rsp_dat_o = 0.
REQ-021 Minimum latency: cmd handshake edge E0, bus active cycle E0..E1, rsp_valid_o high after E1, i.e. 2 edges.
REQ-022 In RESP, SHALL hold rsp_valid_o and rsp_dat_o/rsp_err_o stable until rsp_ready_i is sampled high, then return to IDLE.
REQ-023 SHALL drop rsp_valid_o the cycle after the rsp handshake; no new command is accepted in the same cycle, so back-to-back spacing is at least 3 cycles.
REQ-024 SHALL ignore ack_i/err_i outside BUS.
REQ-025 SHALL drop wbm_stb_o and wbm_cyc_o together; cyc is never high without stb.
REQ-026 SHALL increment txn_cnt_o on every entry to RESP, error or not; it wraps from 0xFFFF to 0.

Reset
REQ-027 While wb_rst_i is high at an edge, SHALL force state IDLE and zero cyc, stb, we, adr, dat, sel, rsp_valid, rsp_dat, rsp_err and txn_cnt; cmd_ready_o is 1 after reset.
REQ-028 Reset asserted mid-BUS SHALL drop cyc/stb at that edge with no response generated and no count increment.

Configuration
REQ-029 Macro WB_HOST_TIMEOUT_EN: when defined, a 16-bit counter SHALL clear on entry to BUS and increment each BUS cycle without ack/err.
REQ-030 With the macro defined, on reaching TIMEOUT_CYCLES the block SHALL drop cyc/stb, give rsp_err_o = 1 and rsp_dat_o = 0, and enter RESP.
REQ-031 When the macro is undefined, BUS SHALL wait indefinitely, with no counter logic and TIMEOUT_CYCLES unused.

Structure
REQ-032 Package wb_host_pkg SHALL hold the FSM state typedef and the constants WB_AW=32, WB_DW=32, WB_SW=4 and TXN_CNT_W=16.
REQ-033 One sub-module, wb_host_timer (clear, enable, limit, expired), SHALL be instantiated only under WB_HOST_TIMEOUT_EN.

Verification
REQ-034 Write adr 0x3000_0004, dat 0xA5A5_5A5A, sel 0xF, slave acks on the first stb cycle: bus shows these values with we=1 for exactly one cycle; rsp_err 0; txn_cnt 1.
REQ-035 Read adr 0x3000_0000, slave acks after 3 wait states with dat 0x1234_5678: cyc/stb high for 4 cycles; rsp_dat 0x1234_5678; rsp_valid held while rsp_ready is low for 5 cycles.
REQ-036 Slave asserts err_i together with ack_i: rsp_err 1, rsp_dat 0, txn_cnt increments.
REQ-037 With WB_HOST_TIMEOUT_EN and TIMEOUT_CYCLES=4, slave never acks: cyc drops after 4 bus cycles and rsp_err is 1; without the macro, cyc stays high for 1000 cycles.
REQ-038 Reset pulsed on the 2nd BUS cycle: cyc/stb low next cycle, rsp_valid never rises, txn_cnt stays 0, and the next command completes normally.
REQ-039 Preload txn_cnt to 0xFFFF via 65535 transactions, then one more: txn_cnt reads 0.

Source files
------------

// File: rtl/wb_host_pkg.sv
// wb_host_pkg: shared widths and FSM state type for the Wishbone host sequencer.
package wb_host_pkg;

  localparam int WB_AW     = 32;
  localparam int WB_DW     = 32;
  localparam int WB_SW     = 4;
  localparam int TXN_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/wb_host_timer.sv
// wb_host_timer: 16-bit bus-cycle watchdog. The count is cleared when a command
// is accepted and advances on every BUS cycle that sees neither ack nor err.
// expired_o flags the edge that completes the limit-th such cycle.
module wb_host_timer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        enable_i,
  input  logic [15:0] limit_i,
  output logic        expired_o
);

  logic [15:0] count_q;
  logic [15:0] count_d;

  // The 17-bit compare keeps the test free of wrap at the top of the range.
  assign expired_o = enable_i && (({1'b0, count_q} + 17'd1) >= {1'b0, limit_i});

  // Next count: clear wins, otherwise count idle BUS cycles until expiry.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = 16'd0;
    end else if (enable_i && !expired_o) begin
      count_d = count_q + 16'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/wb_host_seq.sv
// wb_host_seq: turns one command at a time into a Wishbone classic single
// transfer and returns the result on a valid/ready response channel.
// IDLE -> BUS -> RESP -> IDLE; all outputs come straight from flops.
// Optional build macro WB_HOST_TIMEOUT_EN adds a watchdog that aborts a BUS
// phase after TIMEOUT_CYCLES cycles without ack/err and reports an error.
module wb_host_seq
  import wb_host_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_we_i,
  input  logic [WB_AW-1:0]     cmd_adr_i,
  input  logic [WB_DW-1:0]     cmd_dat_i,
  input  logic [WB_SW-1:0]     cmd_sel_i,
  output logic                 wbm_cyc_o,
  output logic                 wbm_stb_o,
  output logic                 wbm_we_o,
  output logic [WB_AW-1:0]     wbm_adr_o,
  output logic [WB_DW-1:0]     wbm_dat_o,
  output logic [WB_SW-1:0]     wbm_sel_o,
  input  logic [WB_DW-1:0]     wbm_dat_i,
  input  logic                 wbm_ack_i,
  input  logic                 wbm_err_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [WB_DW-1:0]     rsp_dat_o,
  output logic                 rsp_err_o,
  output logic [TXN_CNT_W-1:0] txn_cnt_o
);

  state_e                 state_q, state_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic                   cyc_q, cyc_d;
  logic                   stb_q, stb_d;
  logic                   we_q, we_d;
  logic [WB_AW-1:0]       adr_q, adr_d;
  logic [WB_DW-1:0]       dat_q, dat_d;
  logic [WB_SW-1:0]       sel_q, sel_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [WB_DW-1:0]       rsp_dat_q, rsp_dat_d;
  logic                   rsp_err_q, rsp_err_d;
  logic [TXN_CNT_W-1:0]   txn_cnt_q, txn_cnt_d;
  logic                   timeout_s;

`ifdef WB_HOST_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  logic tmr_clear_s;
  logic tmr_en_s;

  assign tmr_clear_s = (state_q == ST_IDLE) && cmd_valid_i;
  assign tmr_en_s    = (state_q == ST_BUS) && !wbm_ack_i && !wbm_err_i;

  wb_host_timer u_timer (
    .clk_i     (wb_clk_i),
    .rst_i     (wb_rst_i),
    .clear_i   (tmr_clear_s),
    .enable_i  (tmr_en_s),
    .limit_i   (TIMEOUT_LIMIT),
    .expired_o (timeout_s)
  );
`else
  // Without the watchdog a BUS phase only ends on ack or err.
  assign timeout_s = 1'b0;
`endif

  // Next-state and next-output logic; ack/err are only looked at in BUS.
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    txn_cnt_d   = txn_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          state_d = ST_BUS;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = cmd_we_i;
          adr_d   = cmd_adr_i;
          dat_d   = cmd_dat_i;
          sel_d   = cmd_sel_i;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUS: begin
        if (wbm_err_i || wbm_ack_i || timeout_s) begin
          // err beats ack; a timeout is reported as an error with no data.
          state_d     = ST_RESP;
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = wbm_err_i || !wbm_ack_i;
          rsp_dat_d   = (wbm_ack_i && !wbm_err_i && !we_q) ? wbm_dat_i : 32'h0000_0000;
          txn_cnt_d   = txn_cnt_q + 16'd1;
        end else begin
          state_d = ST_BUS;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        cyc_d       = 1'b0;
        stb_d       = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
    cmd_ready_d = (state_d == ST_IDLE);
  end

  // State and output registers; reset abandons any bus cycle without a response.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= 32'h0000_0000;
      dat_q       <= 32'h0000_0000;
      sel_q       <= 4'h0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= 32'h0000_0000;
      rsp_err_q   <= 1'b0;
      txn_cnt_q   <= 16'h0000;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      txn_cnt_q   <= txn_cnt_d;
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = stb_q;
  assign wbm_we_o    = we_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
  assign wbm_sel_o   = sel_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;
  assign txn_cnt_o   = txn_cnt_q;

endmodule
